// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the word-indexed ROM and fills the IF/ID register.
// Optional FETCH_COUNTERS_EN macro adds saturating fetch/stall event counters.
module instruction_fetch #(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
  parameter logic [PC_WIDTH-1:0] PC_STEP     = {{(PC_WIDTH-1){1'b0}}, 1'b1},
  parameter int                  IMEM_DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instrucao,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   if_valid,
  output logic                   halted
`ifdef FETCH_COUNTERS_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] DEPTH_PC = PC_WIDTH'(IMEM_DEPTH);

  state_t                 state_r,    state_s;
  logic [PC_WIDTH-1:0]    pc_r,       pc_s;
  logic [INSTR_WIDTH-1:0] if_instr_r, if_instr_s;
  logic [PC_WIDTH-1:0]    if_pc_r,    if_pc_s;
  logic                   if_valid_r, if_valid_s;
  logic                   halted_r,   halted_s;
  logic                   in_range_s;
  logic                   target_ok_s;

  assign in_range_s  = (pc_r < DEPTH_PC);
  assign target_ok_s = (branch_target < DEPTH_PC);

  assign pc       = pc_r;
  assign if_instr = if_instr_r;
  assign if_pc    = if_pc_r;
  assign if_valid = if_valid_r;
  assign halted   = halted_r;

  // Next-state and next-register computation; branch beats stall beats normal fetch.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    if_instr_s = if_instr_r;
    if_pc_s    = if_pc_r;
    if_valid_s = if_valid_r;
    halted_s   = halted_r;
    case (state_r)
      IDLE: begin
        state_s = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          // The word read this cycle is on the wrong path, so drop it.
          pc_s       = branch_target;
          if_valid_s = 1'b0;
        end else if (stall) begin
          pc_s = pc_r;
        end else if (in_range_s) begin
          if_instr_s = instrucao;
          if_pc_s    = pc_r;
          if_valid_s = 1'b1;
          pc_s       = pc_r + PC_STEP;
        end else begin
          if_valid_s = 1'b0;
          halted_s   = 1'b1;
          state_s    = HALT;
        end
      end
      HALT: begin
        if_valid_s = 1'b0;
        if (branch_taken && target_ok_s) begin
          pc_s     = branch_target;
          halted_s = 1'b0;
          state_s  = RUN;
        end else begin
          pc_s = pc_r;
        end
      end
      default: begin
        state_s    = IDLE;
        if_valid_s = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      if_instr_r <= {INSTR_WIDTH{1'b0}};
      if_pc_r    <= {PC_WIDTH{1'b0}};
      if_valid_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      if_instr_r <= if_instr_s;
      if_pc_r    <= if_pc_s;
      if_valid_r <= if_valid_s;
      halted_r   <= halted_s;
    end
  end

`ifdef FETCH_COUNTERS_EN
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;
  logic        fetch_inc_s;
  logic        stall_inc_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  assign fetch_inc_s = (state_r == RUN) && !branch_taken && !stall && in_range_s;
  assign stall_inc_s = (state_r == RUN) && !branch_taken && stall;
  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_r <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (fetch_inc_s) begin
        fetch_count_r <= sat_inc(fetch_count_r);
      end
      if (stall_inc_s) begin
        stall_count_r <= sat_inc(stall_count_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized stall/branch
// traffic, checked every cycle against a behavioural fetch model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc;
  logic [31:0] instrucao;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] rom [0:63];

  int total = 0;
  int bad   = 0;

  // behavioural model of the fetch stage
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_started;
  int unsigned m_fetches, m_stalls;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instrucao     (instrucao),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted)
`ifdef FETCH_COUNTERS_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  assign instrucao = (pc < 64'd64) ? rom[pc[5:0]] : 32'hDEAD_BEEF;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_ipc = 64'd0; m_instr = 32'd0;
    m_valid = 1'b0; m_halted = 1'b0; m_started = 1'b0;
    m_fetches = 0; m_stalls = 0;
  endtask

  // One clock edge of the fetch stage, seen from its rules rather than its encoding.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_halted) begin
      m_valid = 1'b0;
      if (branch_taken && branch_target < 64'd64) begin
        m_pc = branch_target;
        m_halted = 1'b0;
      end
    end else if (branch_taken) begin
      m_pc = branch_target;
      m_valid = 1'b0;
    end else if (stall) begin
      m_stalls++;
    end else if (m_pc < 64'd64) begin
      m_instr = rom[m_pc[5:0]];
      m_ipc = m_pc;
      m_valid = 1'b1;
      m_pc = m_pc + 64'd1;
      m_fetches++;
    end else begin
      m_valid = 1'b0;
      m_halted = 1'b1;
    end
  endtask

  task automatic check_cycle();
    cmp("pc", pc, m_pc);
    cmp("if_valid", {63'd0, if_valid}, {63'd0, m_valid});
    cmp("halted", {63'd0, halted}, {63'd0, m_halted});
    if (m_valid) begin
      cmp("if_instr", {32'd0, if_instr}, {32'd0, m_instr});
      cmp("if_pc", if_pc, m_ipc);
    end
`ifdef FETCH_COUNTERS_EN
    cmp("fetch_count", {32'd0, fetch_count}, {32'd0, m_fetches});
    cmp("stall_count", {32'd0, stall_count}, {32'd0, m_stalls});
`endif
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[1]  = 32'h0070_2083;
    rom[7]  = 32'd0;
    rom[20] = 32'd0;
    model_reset();

    // reset held for three cycles
    cycle(3);
    cmp("rst_pc", pc, 64'd0);
    cmp("rst_valid", {63'd0, if_valid}, 64'd0);
    cmp("rst_halted", {63'd0, halted}, 64'd0);
    cmp("rst_instr", {32'd0, if_instr}, 64'd0);
    cmp("rst_ifpc", if_pc, 64'd0);

    // release: one idle edge, then sequential fetch
    reset = 1'b0;
    cycle(1);
    cmp("idle_pc", pc, 64'd0);
    cmp("idle_valid", {63'd0, if_valid}, 64'd0);
    cycle(1);
    cmp("seq_pc1", pc, 64'd1);
    cycle(1);
    cmp("seq_pc2", pc, 64'd2);
    cmp("rom1_instr", {32'd0, if_instr}, 64'h0070_2083);
    cmp("rom1_ifpc", if_pc, 64'd1);
    cmp("rom1_valid", {63'd0, if_valid}, 64'd1);
    cycle(1);

    // two-cycle stall at pc=3
    stall = 1'b1;
    cycle(2);
    cmp("stall_pc", pc, 64'd3);
    cmp("stall_ifpc", if_pc, 64'd2);
    stall = 1'b0;
    cycle(1);
    cmp("resume_pc", pc, 64'd4);
    cmp("resume_ifpc", if_pc, 64'd3);

    // branch wins over a simultaneous stall
    branch_taken = 1'b1; branch_target = 64'd10; stall = 1'b1;
    cycle(1);
    cmp("br_pc", pc, 64'd10);
    cmp("br_valid", {63'd0, if_valid}, 64'd0);
    branch_taken = 1'b0; stall = 1'b0;
    cycle(1);
    cmp("br_ifpc", if_pc, 64'd10);
    cmp("br_valid2", {63'd0, if_valid}, 64'd1);

    // randomized stall/branch traffic, including out-of-range targets
    for (int r = 0; r < 600; r++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_target = 64'($urandom_range(0, 72));
      cycle(1);
    end
    stall = 1'b0;

    // run off the end of the ROM and halt
    branch_taken = 1'b1; branch_target = 64'd60;
    cycle(1);
    branch_taken = 1'b0;
    cycle(5);
    cmp("halt_flag", {63'd0, halted}, 64'd1);
    cmp("halt_pc", pc, 64'd64);
    cmp("halt_valid", {63'd0, if_valid}, 64'd0);
    stall = 1'b1;
    cycle(1);
    stall = 1'b0;
    branch_taken = 1'b1; branch_target = 64'd100;
    cycle(1);
    cmp("halt_oor_br", {63'd0, halted}, 64'd1);
    branch_target = 64'd2;
    cycle(1);
    cmp("unhalt_flag", {63'd0, halted}, 64'd0);
    cmp("unhalt_pc", pc, 64'd2);
    branch_taken = 1'b0;
    cycle(1);
    cmp("unhalt_ifpc", if_pc, 64'd2);

    // asynchronous reset in the middle of a stall at pc=5
    branch_taken = 1'b1; branch_target = 64'd5;
    cycle(1);
    branch_taken = 1'b0; stall = 1'b1;
    cycle(1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    cmp("async_pc", pc, 64'd0);
    cmp("async_valid", {63'd0, if_valid}, 64'd0);
    cmp("async_halted", {63'd0, halted}, 64'd0);
    stall = 1'b0;
    cycle(1);

    // five fetches then two stall cycles
    reset = 1'b0;
    cycle(1);
    cycle(5);
    stall = 1'b1;
    cycle(2);
    cmp("cnt_pc", pc, 64'd5);
`ifdef FETCH_COUNTERS_EN
    cmp("fetch_count5", {32'd0, fetch_count}, 64'd5);
    cmp("stall_count2", {32'd0, stall_count}, 64'd2);
`endif
    stall = 1'b0;
    cycle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
